shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit controller for the RISC-V datapath.
- Sequences a 1-bit-per-cycle shift register through shamt steps to execute SLL/SRL/SRA without a barrel shifter.
- Sits beside the ALU; the core issues start and stalls on busy until done.
- Each step is the same 1-bit shift primitive used by the PC logic, applied iteratively.

Parameters:
- N, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- data_in  input  N  operand; captured when start is accepted.
- shamt  input  SHAMT_W  shift amount; captured when start is accepted.
- busy  output  1  high while shifting (SHIFT state).
- done  output  1  one-cycle pulse; result valid.
- result  output  N  shifted value.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, SHIFT, DONE. Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, remaining count=0. rst has priority over start.
- Reset mid-operation aborts the operation. No done is produced and result goes to 0.
- Start acceptance:
  - start is accepted in IDLE or DONE, which allows back-to-back operations.
  - start is ignored in SHIFT. No queueing; the input is dropped silently.
- On acceptance:
  - Working register <- data_in; op and shamt are latched; remaining <- shamt.
  - Next state is SHIFT if shamt != 0, else DONE.
- In SHIFT, each edge performs one step and remaining decrements by 1:
  - SLL: {w[N-2:0],1'b0}
  - SRL: {1'b0,w[N-1:1]}
  - SRA: {w[N-1],w[N-1:1]}
- When remaining==1 at an edge, that step executes and the next state is DONE.
- Latency: start high in cycle c gives busy=1 in cycles c+1..c+shamt and done=1 in cycle c+1+shamt. With shamt=0, done is in cycle c+1 and result=data_in.
- DONE lasts exactly one cycle:
  - done=1 and busy=0.
  - Next state is IDLE, or SHIFT/DONE if start is accepted in that same cycle.
- result:
  - Equals the working register.
  - Guaranteed valid only while done=1; it may change during SHIFT.
  - Holds its final value in IDLE until the next accepted start.
- SRA fills with the sign bit of the original operand (w[N-1] is preserved on each step).
- op=11 behaves identically to SLL.
- shamt >= N is not possible for the defaults. For other parameterizations, values >= N run to completion: SLL/SRL give 0, SRA gives all sign bits.

Optional Feature:
- Macro: SHIFT_STEP4_EN.
- Defined:
  - Each SHIFT edge shifts by 4 if remaining >= 4, else by 1; remaining decrements by the same amount.
  - done occurs in cycle c+1+floor(shamt/4)+(shamt mod 4).
  - The shamt=0 case is unchanged.
- Undefined: exactly 1 bit per cycle, as above.
- Results are bit-identical in both builds.

Test Plan (N=32, feature off unless stated):
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, result=0x00000000; no operation starts.
- SLL: data_in=0x00000001, shamt=4, start in cycle c -> busy=1 in c+1..c+4; done=1 only in c+5; result=0x00000010.
- Fills: SRA with data_in=0x80000000, shamt=31 -> done in c+32, result=0xFFFFFFFF. SRL with the same operands -> result=0x00000001.
- Zero shift and op=11: op=11, data_in=0xDEADBEEF, shamt=0 -> done in c+1, result=0xDEADBEEF, busy never high.
- Busy and abort:
  - start again in c+2 of a shamt=8 operation -> ignored; done in c+9 with the first result.
  - Separate run: rst=1 in c+3 -> IDLE, no done pulse, result=0.
- Back-to-back and step-4: start accepted in the DONE cycle -> second done at the correct offset with no idle cycle. With SHIFT_STEP4_EN defined, SLL shamt=9 -> done in c+4 (2 steps of 4, then 1 step of 1).

Source files
------------

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit controller that sits beside the ALU. Instead of a
// barrel shifter it runs a working register through shamt applications of a
// 1-bit shift primitive (SLL / SRL / SRA). The core pulses start, stalls on
// busy, and picks the result up on the one-cycle done pulse.
//
// Optional build macro: SHIFT_STEP4_EN
//   When defined, each SHIFT cycle applies the primitive four times if at
//   least four steps remain, otherwise once. Results are bit-identical to the
//   default build; only the latency changes.
//
// Parameters:
//   N        datapath width in bits
//   SHAMT_W  shift-amount width (2**SHAMT_W >= N)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous, active-high reset (priority over start)
//   start    request pulse, accepted in IDLE or DONE, ignored in SHIFT
//   op       00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//   data_in  operand, captured when start is accepted
//   shamt    shift amount, captured when start is accepted
//   busy     high while in SHIFT
//   done     one-cycle pulse, result valid
//   result   working register; holds its final value in IDLE
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int N       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [N-1:0]       data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state, state_next;
    logic [N-1:0]       w, w_next;
    logic [1:0]         op_q, op_next;
    logic [SHAMT_W-1:0] remaining, remaining_next;
    logic [SHAMT_W-1:0] step;
    logic               accept;

    // The single 1-bit shift primitive; every step, including the 4-bit
    // stride, is built from repeated applications of it. Anything other than
    // SRL/SRA (including op=11) shifts left.
    function automatic logic [N-1:0] shift1(input logic [N-1:0] v,
                                            input logic [1:0]   o);
        logic [N-1:0] r;
        case (o)
            OP_SRL:  r = {1'b0, v[N-1:1]};
            OP_SRA:  r = {v[N-1], v[N-1:1]};   // sign bit replicated each step
            default: r = {v[N-2:0], 1'b0};
        endcase
        return r;
    endfunction

    // A new request is taken whenever we are not mid-shift; taking it in DONE
    // is what gives back-to-back operation with no idle cycle.
    assign accept = start && (state != SHIFT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves one unassigned and no latch is inferred.
        state_next     = state;
        w_next         = w;
        op_next        = op_q;
        remaining_next = remaining;
        step           = '0;

        case (state)
            SHIFT: begin
`ifdef SHIFT_STEP4_EN
                if (remaining >= SHAMT_W'(4)) begin
                    step = SHAMT_W'(4);
                    for (int i = 0; i < 4; i++) begin
                        w_next = shift1(w_next, op_q);
                    end
                end else begin
                    step   = SHAMT_W'(1);
                    w_next = shift1(w, op_q);
                end
`else
                step   = SHAMT_W'(1);
                w_next = shift1(w, op_q);
`endif
                remaining_next = remaining - step;
                // Leave SHIFT on the edge that consumes the last steps.
                state_next     = (remaining == step) ? DONE : SHIFT;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (accept) begin
            w_next         = data_in;
            op_next        = op;
            remaining_next = shamt;
            state_next     = (shamt != '0) ? SHIFT : DONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (rst) begin
            state     <= IDLE;
            w         <= '0;
            op_q      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            w         <= w_next;
            op_q      <= op_next;
            remaining <= remaining_next;
        end
    end

    // Outputs depend on registered state only; no input reaches them
    // combinationally.
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign result = w;

endmodule
